// File: rtl/acorn128_state_engine_if.sv
// Handshake bundle for acorn128_state_engine.
// The master side (phase controller / bench) offers beats and accepts results.
// The slave side (state engine) consumes beats and presents results.
interface acorn128_state_engine_if #(
  parameter int STEPS = 8
);
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_mode;
  logic               in_ca;
  logic               in_cb;
  logic [STEPS-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [STEPS-1:0]   out_data;
  logic [292:0]       state_out;

  modport master (
    output clear, in_valid, in_mode, in_ca, in_cb, in_data, out_ready,
    input  in_ready, out_valid, out_data, state_out
  );

  modport slave (
    input  clear, in_valid, in_mode, in_ca, in_cb, in_data, out_ready,
    output in_ready, out_valid, out_data, state_out
  );
endinterface

// File: rtl/acorn128_state_engine.sv
// ACORN-128 state engine: STEPS chained state-update steps per accepted beat,
// with a registered result stage behind a valid/ready handshake.
// Optional feature macro: ACORN128_DECRYPT_EN. When defined, in_mode=2 feeds
// the recovered plaintext (c ^ ks) back into the state; when undefined,
// in_mode=2 is handled exactly like encrypt.
module acorn128_state_engine #(
  parameter int STEPS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  acorn128_state_engine_if.slave bus
);

  // Majority of three bits.
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Choose: y where x is set, z otherwise.
  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // One state-update step. Returns {ks, next_state}.
  function automatic logic [293:0] acorn_step(
    input logic [292:0] s_in,
    input logic         din,
    input logic         ca,
    input logic         cb,
    input logic         dec
  );
    logic [292:0] s;
    logic         ks;
    logic         f;
    logic         m;
    s = s_in;
    // LFSR taps, in this order: each update sees the not-yet-updated lower tap.
    s[289] = s[289] ^ s[235] ^ s[230];
    s[230] = s[230] ^ s[196] ^ s[193];
    s[193] = s[193] ^ s[160] ^ s[154];
    s[154] = s[154] ^ s[111] ^ s[107];
    s[107] = s[107] ^ s[66]  ^ s[61];
    s[61]  = s[61]  ^ s[23]  ^ s[0];
    ks = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
    f  = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ (ca & s[196]) ^ (cb & ks);
    m  = dec ? (din ^ ks) : din;
    return {ks, (f ^ m), s[292:1]};
  endfunction

  logic [292:0]     state_reg;
  logic [STEPS-1:0] data_reg;
  logic             valid_reg;

  logic             xor_out;
  logic             dec_fb;
  logic [292:0]     next_state;
  logic [STEPS-1:0] ks_bits;
  logic [STEPS-1:0] result_bits;
  logic             accept;

  // Mode decode: absorb emits keystream; encrypt/decrypt emit data ^ keystream.
  always_comb begin
    xor_out = 1'b0;
    dec_fb  = 1'b0;
    case (bus.in_mode)
      2'd0: begin
        xor_out = 1'b0;
        dec_fb  = 1'b0;
      end
      2'd1: begin
        xor_out = 1'b1;
        dec_fb  = 1'b0;
      end
      2'd2: begin
        xor_out = 1'b1;
`ifdef ACORN128_DECRYPT_EN
        dec_fb  = 1'b1;
`else
        dec_fb  = 1'b0;
`endif
      end
      default: begin
        xor_out = 1'b0;
        dec_fb  = 1'b0;
      end
    endcase
  end

  // Chain STEPS update steps combinationally from the current state.
  always_comb begin
    logic [293:0] step_res;
    next_state = state_reg;
    ks_bits    = '0;
    step_res   = '0;
    for (int k = 0; k < STEPS; k++) begin
      step_res   = acorn_step(next_state, bus.in_data[k], bus.in_ca, bus.in_cb, dec_fb);
      next_state = step_res[292:0];
      ks_bits[k] = step_res[293];
    end
    if (xor_out) begin
      result_bits = bus.in_data ^ ks_bits;
    end else begin
      result_bits = ks_bits;
    end
  end

  // Clear blocks acceptance; otherwise a beat goes in when the result slot is free or draining.
  assign bus.in_ready = ~bus.clear & (bus.out_ready | ~valid_reg);
  assign accept       = bus.in_valid & bus.in_ready;

  // State and result registers: clear beats accept, accept beats drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= 293'd0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (bus.clear) begin
      state_reg <= 293'd0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (accept) begin
      state_reg <= next_state;
      data_reg  <= result_bits;
      valid_reg <= 1'b1;
    end else if (bus.out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = valid_reg;
  assign bus.out_data  = data_reg;
  assign bus.state_out = state_reg;

endmodule
